sram_axi_bridge: RTL and testbench

Converts NUM_PORTS SRAM-like request ports (req/addr_ok/data_ok) from the CPU core into one AXI3 master interface. It sits between the core and the external AXI interconnect inside the CPU top. Compared with the single inst/data bridge, it adds:
- a parametrised port count;
- up to RD_DEPTH outstanding reads per port, routed back by ID;
- fixed-priority arbitration;
- a read-after-write address hazard check.

---
 rtl/sram_axi_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges NUM_PORTS SRAM-like request ports onto one AXI3 master.
// All ports share one AR slot. Each port may have up to RD_DEPTH reads in flight,
// and read data is routed back to the port named by RID. Only one write can be in
// flight at a time. Port 0 has the highest priority for both reads and writes.
// The AXI W-channel data output is named wdata_o because the core-side write data
// input already uses the name wdata.
`timescale 1ns/1ps
module sram_axi_bridge #(
    parameter int NUM_PORTS = 2,
    parameter int RD_DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    // core side, port i occupies slice i
    input  logic [NUM_PORTS-1:0]      req,
    input  logic [NUM_PORTS-1:0]      wr,
    input  logic [2*NUM_PORTS-1:0]    size,
    input  logic [4*NUM_PORTS-1:0]    wstrb,
    input  logic [32*NUM_PORTS-1:0]   addr,
    input  logic [32*NUM_PORTS-1:0]   wdata,
    output logic [NUM_PORTS-1:0]      addr_ok,
    output logic [NUM_PORTS-1:0]      data_ok,
    output logic [32*NUM_PORTS-1:0]   rdata_o,
    // AXI AR
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    // AXI R
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    // AXI AW
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    // AXI W
    output logic [3:0]                wid,
    output logic [31:0]               wdata_o,
    output logic [3:0]                wstrb_o,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    // AXI B
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam logic [2:0] RD_MAX = 3'(RD_DEPTH);

    logic                 ar_busy;
    logic [2:0]           rd_cnt [NUM_PORTS];
    logic                 wr_pend;
    logic                 aw_busy;
    logic                 w_busy;
    logic [3:0]           wr_port;

    logic [NUM_PORTS-1:0] rd_elig;
    logic [NUM_PORTS-1:0] wr_elig;
    logic [NUM_PORTS-1:0] rd_grant;
    logic [NUM_PORTS-1:0] wr_grant;
    logic [NUM_PORTS-1:0] r_hit;
    logic                 rd_take;
    logic                 wr_take;
    logic [3:0]           rd_sel;
    logic [3:0]           wr_sel;
    logic [31:0]          rd_addr_sel;
    logic [1:0]           rd_size_sel;
    logic [31:0]          wr_addr_sel;
    logic [1:0]           wr_size_sel;
    logic [31:0]          wr_data_sel;
    logic [3:0]           wr_strb_sel;

    // Response status and error bits are not used by the core.
    logic                 unused_inputs;
    assign unused_inputs = ^{rresp, rlast, bid, bresp};

    assign arlen   = 8'd0;
    assign arburst = 2'd1;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'd1;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign arvalid = ar_busy;
    assign awvalid = aw_busy;
    assign wvalid  = w_busy;
    assign awid    = wr_port;
    assign wid     = wr_port;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    // A B response is held back for one cycle when a read beat for the writing port
    // arrives, so that port never sees two completions in the same cycle.
    assign bready  = !(rvalid && (rid == wr_port));

    // Per-port eligibility: depth limit and read-after-write hazard for reads,
    // no reads in flight for writes.
    always_comb begin
        rd_elig = '0;
        wr_elig = '0;
        r_hit   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            r_hit[i]   = rvalid && (rid == 4'(i));
            rd_elig[i] = req[i] && !wr[i] && (rd_cnt[i] < RD_MAX)
                         && !(wr_pend && (addr[32*i+2 +: 30] == awaddr[31:2]));
            wr_elig[i] = req[i] && wr[i] && (rd_cnt[i] == 3'd0);
        end
    end

    // Fixed-priority pick: scanning downwards leaves the lowest eligible index selected.
    always_comb begin
        rd_take     = 1'b0;
        wr_take     = 1'b0;
        rd_sel      = '0;
        wr_sel      = '0;
        rd_addr_sel = '0;
        rd_size_sel = '0;
        wr_addr_sel = '0;
        wr_size_sel = '0;
        wr_data_sel = '0;
        wr_strb_sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rd_elig[i]) begin
                rd_take     = !ar_busy;
                rd_sel      = 4'(i);
                rd_addr_sel = addr[32*i +: 32];
                rd_size_sel = size[2*i +: 2];
            end
            if (wr_elig[i]) begin
                wr_take     = !wr_pend;
                wr_sel      = 4'(i);
                wr_addr_sel = addr[32*i +: 32];
                wr_size_sel = size[2*i +: 2];
                wr_data_sel = wdata[32*i +: 32];
                wr_strb_sel = wstrb[4*i +: 4];
            end
        end
    end

    // Core-side handshakes: grants, read-return and write-completion routing.
    always_comb begin
        rd_grant = '0;
        wr_grant = '0;
        addr_ok  = '0;
        data_ok  = '0;
        rdata_o  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_grant[i]         = rd_take && (rd_sel == 4'(i));
            wr_grant[i]         = wr_take && (wr_sel == 4'(i));
            addr_ok[i]          = rd_grant[i] || wr_grant[i];
            data_ok[i]          = r_hit[i] || (bvalid && bready && (wr_port == 4'(i)));
            rdata_o[32*i +: 32] = rdata;
        end
    end

    // AR slot: load on a read grant, release on the AR handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_busy <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
        end else if (rd_take) begin
            ar_busy <= 1'b1;
            arid    <= rd_sel;
            araddr  <= rd_addr_sel;
            arsize  <= {1'b0, rd_size_sel};
        end else if (arready) begin
            ar_busy <= 1'b0;
        end
    end

    // Outstanding reads per port: up on a grant, down on a returned beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                case ({rd_grant[i], r_hit[i]})
                    2'b10:   rd_cnt[i] <= rd_cnt[i] + 3'd1;
                    2'b01:   rd_cnt[i] <= rd_cnt[i] - 3'd1;
                    default: rd_cnt[i] <= rd_cnt[i];
                endcase
            end
        end
    end

    // Single write in flight: AW and W load together and retire independently.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_pend <= 1'b0;
            aw_busy <= 1'b0;
            w_busy  <= 1'b0;
            wr_port <= '0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata_o <= '0;
            wstrb_o <= '0;
        end else if (wr_take) begin
            wr_pend <= 1'b1;
            aw_busy <= 1'b1;
            w_busy  <= 1'b1;
            wr_port <= wr_sel;
            awaddr  <= wr_addr_sel;
            awsize  <= {1'b0, wr_size_sel};
            wdata_o <= wr_data_sel;
            wstrb_o <= wr_strb_sel;
        end else begin
            if (awready) begin
                aw_busy <= 1'b0;
            end
            if (wready) begin
                w_busy <= 1'b0;
            end
            if (bvalid && bready) begin
                wr_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Testbench for sram_axi_bridge (NUM_PORTS=2, RD_DEPTH=2): a table of single reads,
// hand-written multi-cycle sequences and a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_sram_axi_bridge;
    localparam int NP    = 2;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NP-1:0]   req, wr;
    logic [2*NP-1:0] size;
    logic [4*NP-1:0] wstrb;
    logic [32*NP-1:0] addr, wdata;
    logic [NP-1:0]   addr_ok, data_ok;
    logic [32*NP-1:0] rdata_o;
    logic [3:0]  arid;   logic [31:0] araddr; logic [2:0] arsize; logic arvalid, arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;  logic rlast, rvalid, rready;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [2:0] awsize; logic awvalid, awready;
    logic [3:0]  wid;    logic [31:0] wdata_o; logic [3:0] wstrb_o; logic wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0] bresp;   logic bvalid, bready;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [3:0]  arcache, awcache;
    logic [2:0]  arprot, awprot;

    int checks = 0;
    int errors = 0;

    sram_axi_bridge #(.NUM_PORTS(NP), .RD_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata_o(rdata_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] d;
        logic [2:0]  exp_arsize;
        logic [1:0]  exp_ok;
    } rd_vec_t;
    rd_vec_t vecs[4];

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [2:0]  sz;
    } ar_t;

    // Transaction-level model state for the randomized run.
    ar_t         ar_q[$];
    int          cnt[NP];
    int          ready_rd[NP];
    int          cand[$];
    bit          wr_active, aw_done, w_done, b_on;
    int          wr_port_m;
    logic [31:0] wr_addr_m, wr_data_m;
    logic [3:0]  wr_strb_m;
    logic [2:0]  wr_size_m;
    int          exp_rd, exp_wr;
    logic        exp_bready;
    logic [1:0]  exp_ok, exp_dok;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int p, input logic r, input logic w, input logic [31:0] a,
                                 input logic [1:0] sz, input logic [3:0] st, input logic [31:0] d);
        req[p]            = r;
        wr[p]             = w;
        addr[32*p +: 32]  = a;
        size[2*p +: 2]    = sz;
        wstrb[4*p +: 4]   = st;
        wdata[32*p +: 32] = d;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0102;
            2:       return 32'h0000_0104;
            default: return 32'h0000_0200;
        endcase
    endfunction

    task automatic idle_inputs();
        req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
        bvalid = 1'b0; bid = '0; bresp = '0;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: still running at %0t, expected finish before 500000", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vecs[0] = '{1, 32'h1c00_0000, 2'd2, 32'hdead_beef, 3'd2, 2'b10};
        vecs[1] = '{0, 32'h0000_0040, 2'd0, 32'h0000_00a5, 3'd0, 2'b01};
        vecs[2] = '{1, 32'h8000_0002, 2'd1, 32'h1234_5678, 3'd1, 2'b10};
        vecs[3] = '{0, 32'hbfc0_0000, 2'd2, 32'hcafe_f00d, 3'd2, 2'b01};

        // ---------------- reset state ----------------
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
        checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
        checkOutput("rst_rready", 32'(rready), 32'd1);
        checkOutput("rst_bready", 32'(bready), 32'd1);
        checkOutput("rst_burst", 32'({arburst, awburst}), 32'h5);
        checkOutput("rst_consts", 32'({arlen, awlen, arlock, awlock, arcache, awcache, arprot, awprot}), 32'd0);
        checkOutput("rst_wlast", 32'(wlast), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- table of single reads ----------------
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(vecs[k].port, 1'b1, 1'b0, vecs[k].a, vecs[k].sz, 4'h0, 32'h0);
            #1 checkOutput("tbl_addr_ok", 32'(addr_ok), 32'(vecs[k].exp_ok));
            @(negedge clk);
            req = '0;
            #1;
            checkOutput("tbl_arvalid", 32'(arvalid), 32'd1);
            checkOutput("tbl_arid", 32'(arid), 32'(vecs[k].port));
            checkOutput("tbl_araddr", araddr, vecs[k].a);
            checkOutput("tbl_arsize", 32'(arsize), 32'(vecs[k].exp_arsize));
            @(negedge clk);
            rvalid = 1'b1; rid = 4'(vecs[k].port); rdata = vecs[k].d;
            #1;
            checkOutput("tbl_data_ok", 32'(data_ok), 32'(vecs[k].exp_ok));
            checkOutput("tbl_rdata", rdata_o[32*vecs[k].port +: 32], vecs[k].d);
            checkOutput("tbl_arvalid_done", 32'(arvalid), 32'd0);
            @(negedge clk);
            rvalid = 1'b0;
        end

        // ---------------- simultaneous reads, out-of-order return ----------------
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_1000, 2'd2, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_2000, 2'd2, 4'h0, 32'h0);
        #1 checkOutput("prio_first", 32'(addr_ok), 32'h1);
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        checkOutput("prio_busy", 32'(addr_ok), 32'h0);
        checkOutput("prio_arid0", 32'(arid), 32'd0);
        @(negedge clk);
        #1 checkOutput("prio_second", 32'(addr_ok), 32'h2);
        @(negedge clk);
        req = '0;
        #1;
        checkOutput("prio_arid1", 32'(arid), 32'd1);
        checkOutput("prio_araddr1", araddr, 32'h0000_2000);
        @(negedge clk);
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_aaaa;
        #1;
        checkOutput("ooo_dok1", 32'(data_ok), 32'h2);
        checkOutput("ooo_rdata1", rdata_o[63:32], 32'h1111_aaaa);
        @(negedge clk);
        rid = 4'd0; rdata = 32'h0000_bbbb;
        #1;
        checkOutput("ooo_dok0", 32'(data_ok), 32'h1);
        checkOutput("ooo_rdata0", rdata_o[31:0], 32'h0000_bbbb);
        @(negedge clk);
        rvalid = 1'b0;

        // ---------------- depth limit on port 1 ----------------
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_3000, 2'd2, 4'h0, 32'h0);
        #1 checkOutput("depth_r1", 32'(addr_ok), 32'h2);
        @(negedge clk);
        #1 checkOutput("depth_busy1", 32'(addr_ok), 32'h0);
        @(negedge clk);
        #1 checkOutput("depth_r2", 32'(addr_ok), 32'h2);
        @(negedge clk);
        #1 checkOutput("depth_busy2", 32'(addr_ok), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1 checkOutput("depth_full", 32'(addr_ok), 32'h0);
        end
        @(negedge clk);
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0001;
        #1;
        checkOutput("depth_full_on_beat", 32'(addr_ok), 32'h0);
        checkOutput("depth_beat_dok", 32'(data_ok), 32'h2);
        @(negedge clk);
        rvalid = 1'b0;
        #1 checkOutput("depth_r3", 32'(addr_ok), 32'h2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req = '0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0010 + 32'(k);
            #1 checkOutput("depth_drain", 32'(data_ok), 32'h2);
        end
        @(negedge clk);
        rvalid = 1'b0;

        // ---------------- write with late awready, hazard, B/R conflict ----------------
        awready = 1'b0; wready = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 2'd2, 4'hf, 32'h1234_5678);
        #1 checkOutput("wr_addr_ok", 32'(addr_ok), 32'h1);
        @(negedge clk);
        req = '0;
        #1;
        checkOutput("wr_awvalid", 32'(awvalid), 32'd1);
        checkOutput("wr_wvalid", 32'(wvalid), 32'd1);
        checkOutput("wr_awaddr", awaddr, 32'h0000_0100);
        checkOutput("wr_awsize", 32'(awsize), 32'd2);
        checkOutput("wr_wdata", wdata_o, 32'h1234_5678);
        checkOutput("wr_wstrb", 32'(wstrb_o), 32'hf);
        checkOutput("wr_ids", 32'({awid, wid}), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checkOutput("wr_wvalid_drop", 32'(wvalid), 32'd0);
            checkOutput("wr_awvalid_hold", 32'(awvalid), 32'd1);
        end
        @(negedge clk);
        awready = 1'b1;
        #1 checkOutput("wr_awvalid_last", 32'(awvalid), 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0102, 2'd1, 4'h0, 32'h0);
        #1;
        checkOutput("wr_awvalid_drop", 32'(awvalid), 32'd0);
        checkOutput("hazard_block", 32'(addr_ok), 32'h0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0104, 2'd2, 4'h0, 32'h0);
        #1 checkOutput("hazard_pass", 32'(addr_ok), 32'h1);
        @(negedge clk);
        req = '0;
        #1 checkOutput("hazard_araddr", araddr, 32'h0000_0104);
        @(negedge clk);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0bad_f00d; bvalid = 1'b1; bid = 4'd0;
        #1;
        checkOutput("conflict_bready", 32'(bready), 32'd0);
        checkOutput("conflict_dok_r", 32'(data_ok), 32'h1);
        checkOutput("conflict_rdata", rdata_o[31:0], 32'h0bad_f00d);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        checkOutput("conflict_bready2", 32'(bready), 32'd1);
        checkOutput("conflict_dok_b", 32'(data_ok), 32'h1);
        @(negedge clk);
        bvalid = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 2'd2, 4'h0, 32'h0);
        #1;
        checkOutput("after_b_dok", 32'(data_ok), 32'h0);
        checkOutput("after_b_hazard_gone", 32'(addr_ok), 32'h1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0abc;
        #1 checkOutput("after_b_read", 32'(data_ok), 32'h1);
        @(negedge clk);
        rvalid = 1'b0;

        // ---------------- asynchronous reset with valids high ----------------
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, 2'd2, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0400, 2'd2, 4'hf, 32'h55aa_55aa);
        #1 checkOutput("rw_same_cycle", 32'(addr_ok), 32'h3);
        @(negedge clk);
        req = '0;
        #1;
        checkOutput("pre_rst_arvalid", 32'(arvalid), 32'd1);
        checkOutput("pre_rst_wvalid", 32'(wvalid), 32'd1);
        checkOutput("pre_rst_awid", 32'(awid), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("async_arvalid", 32'(arvalid), 32'd0);
        checkOutput("async_awvalid", 32'(awvalid), 32'd0);
        checkOutput("async_wvalid", 32'(wvalid), 32'd0);
        @(negedge clk);
        resetn = 1'b1; arready = 1'b1; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, 2'd2, 4'h0, 32'h0);
        #1 checkOutput("fresh_addr_ok", 32'(addr_ok), 32'h1);
        @(negedge clk);
        req = '0;
        #1 checkOutput("fresh_araddr", araddr, 32'h0000_0300);
        @(negedge clk);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h7777_0000;
        #1 checkOutput("fresh_data_ok", 32'(data_ok), 32'h1);
        @(negedge clk);
        rvalid = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0500, 2'd2, 4'h3, 32'h0000_beef);
        #1 checkOutput("fresh_write_ok", 32'(addr_ok), 32'h1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        bvalid = 1'b1; bid = 4'd0;
        #1 checkOutput("fresh_write_done", 32'(data_ok), 32'h1);
        @(negedge clk);
        bvalid = 1'b0;

        // ---------------- randomized run against the transaction model ----------------
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        ar_q.delete();
        for (int p = 0; p < NP; p++) begin
            cnt[p] = 0;
            ready_rd[p] = 0;
        end
        wr_active = 1'b0; aw_done = 1'b0; w_done = 1'b0; b_on = 1'b0;
        wr_port_m = 0; wr_addr_m = '0; wr_data_m = '0; wr_strb_m = '0; wr_size_m = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                applyStimulus(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(),
                              2'($urandom_range(0, 2)), 4'($urandom), $urandom);
            end
            arready = 1'($urandom);
            awready = 1'($urandom);
            wready  = 1'($urandom);
            rvalid  = 1'b0;
            cand.delete();
            for (int p = 0; p < NP; p++) begin
                if (ready_rd[p] > 0) cand.push_back(p);
            end
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                rvalid = 1'b1;
                rid    = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                rdata  = $urandom;
            end
            if (wr_active && aw_done && w_done && !b_on && $urandom_range(0, 1) == 1) b_on = 1'b1;
            bvalid = b_on;
            bid    = 4'(wr_port_m);
            #1;

            // expected grants from the arbitration rules
            exp_rd = -1;
            exp_wr = -1;
            for (int p = NP - 1; p >= 0; p--) begin
                if (ar_q.size() == 0 && req[p] && !wr[p] && cnt[p] < DEPTH
                    && !(wr_active && addr[32*p+2 +: 30] == wr_addr_m[31:2])) exp_rd = p;
                if (!wr_active && req[p] && wr[p] && cnt[p] == 0) exp_wr = p;
            end
            exp_ok = '0;
            if (exp_rd >= 0) exp_ok[exp_rd] = 1'b1;
            if (exp_wr >= 0) exp_ok[exp_wr] = 1'b1;
            exp_bready = !(rvalid && rid == 4'(wr_port_m));
            exp_dok = '0;
            for (int p = 0; p < NP; p++) begin
                exp_dok[p] = (rvalid && rid == 4'(p)) || (bvalid && exp_bready && wr_port_m == p);
            end

            checkOutput("rnd_addr_ok", 32'(addr_ok), 32'(exp_ok));
            checkOutput("rnd_data_ok", 32'(data_ok), 32'(exp_dok));
            checkOutput("rnd_bready", 32'(bready), 32'(exp_bready));
            checkOutput("rnd_arvalid", 32'(arvalid), 32'(ar_q.size() > 0));
            checkOutput("rnd_awvalid", 32'(awvalid), 32'(wr_active && !aw_done));
            checkOutput("rnd_wvalid", 32'(wvalid), 32'(wr_active && !w_done));
            if (ar_q.size() > 0) begin
                checkOutput("rnd_arid", 32'(arid), 32'(ar_q[0].id));
                checkOutput("rnd_araddr", araddr, ar_q[0].a);
                checkOutput("rnd_arsize", 32'(arsize), 32'(ar_q[0].sz));
            end
            if (wr_active) begin
                checkOutput("rnd_awid", 32'(awid), 32'(wr_port_m));
                checkOutput("rnd_awaddr", awaddr, wr_addr_m);
                checkOutput("rnd_awsize", 32'(awsize), 32'(wr_size_m));
                checkOutput("rnd_wdata", wdata_o, wr_data_m);
                checkOutput("rnd_wstrb", 32'(wstrb_o), 32'(wr_strb_m));
            end
            if (rvalid) begin
                checkOutput("rnd_rdata", rdata_o[32*int'(rid) +: 32], rdata);
            end

            // advance the model to the state after this clock edge
            if (ar_q.size() > 0 && arready) begin
                ready_rd[ar_q[0].id]++;
                void'(ar_q.pop_front());
            end
            if (rvalid) begin
                cnt[int'(rid)]--;
                ready_rd[int'(rid)]--;
            end
            if (exp_rd >= 0) begin
                ar_q.push_back('{exp_rd, addr[32*exp_rd +: 32], {1'b0, size[2*exp_rd +: 2]}});
                cnt[exp_rd]++;
            end
            if (wr_active) begin
                if (awready) aw_done = 1'b1;
                if (wready)  w_done  = 1'b1;
                if (bvalid && exp_bready) begin
                    wr_active = 1'b0;
                    b_on      = 1'b0;
                end
            end
            if (exp_wr >= 0) begin
                wr_active = 1'b1;
                aw_done   = 1'b0;
                w_done    = 1'b0;
                wr_port_m = exp_wr;
                wr_addr_m = addr[32*exp_wr +: 32];
                wr_size_m = {1'b0, size[2*exp_wr +: 2]};
                wr_data_m = wdata[32*exp_wr +: 32];
                wr_strb_m = wstrb[4*exp_wr +: 4];
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
